// File: rtl/soundgen_poly.sv
// soundgen_poly: frame-ticked wavetable voice + drum stereo mixer with pan and saturation
module soundgen_poly #(
    parameter int NUM_VOICES = 8,
    parameter int NUM_DRUMS  = 2,
    parameter int SAMPLE_W   = 18,
    parameter int ADDR_W     = 10,
    parameter int ENV_W      = 18,
    parameter int DRUM_W     = 16,
    localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1,
    localparam int DN = (NUM_DRUMS > 0) ? NUM_DRUMS : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 tick48k,
    output logic                 voice_req,
    output logic [IW-1:0]        voice_idx,
    input  logic                 voice_ack,
    input  logic                 voice_active,
    input  logic [ADDR_W-1:0]    voice_addr,
    input  logic [ENV_W-1:0]     voice_env,
    input  logic [4:0]           voice_pan,
    output logic                 wt_en,
    output logic [ADDR_W-1:0]    wt_addr,
    input  logic [SAMPLE_W-1:0]  wt_data,
    input  logic [DN*DRUM_W-1:0] drum_sample,
    input  logic [DN-1:0]        drum_valid,
    output logic [SAMPLE_W-1:0]  sound_l,
    output logic [SAMPLE_W-1:0]  sound_r,
    output logic                 sound_valid,
    output logic                 busy,
    output logic                 overrun
);
    localparam int AW = SAMPLE_W + $clog2(NUM_VOICES + NUM_DRUMS) + 1;
    localparam int PW = SAMPLE_W + 1;
    localparam logic [SAMPLE_W-1:0] MID = {1'b1, {(SAMPLE_W-1){1'b0}}};
    localparam logic signed [AW-1:0] MAXV = {{(AW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = ~MAXV;

    typedef enum logic [2:0] {IDLE, REQ, READ, MUL, ACC, DRUM, DONE} state_t;

    state_t                       state_q, state_d;
    logic [IW-1:0]                idx_q;
    logic [ADDR_W-1:0]            addr_q;
    logic [ENV_W-1:0]             env_q;
    logic [4:0]                   pan_q;
    logic signed [PW-1:0]         p_q, p_d;
    logic signed [AW-1:0]         acc_l_q, acc_r_q, cl, cr, drum_sum, sat_l, sat_r;
    logic [DN*DRUM_W-1:0]         drum_q;
    logic [DN-1:0]                dvalid_q;
    logic [SAMPLE_W-1:0]          sound_l_q, sound_r_q;
    logic                         sound_valid_q, overrun_q, last;
    logic signed [SAMPLE_W-1:0]   s, dv;
    logic signed [SAMPLE_W+ENV_W:0] prod;
    logic signed [PW+5:0]         ml, mr;
    logic [DRUM_W-1:0]            raw;

    assign last        = idx_q == IW'(NUM_VOICES - 1);
    assign voice_req   = state_q == REQ;
    assign wt_en       = state_q == READ;
    assign busy        = state_q != IDLE;
    assign voice_idx   = idx_q;
    assign wt_addr     = addr_q;
    assign sound_l     = sound_l_q;
    assign sound_r     = sound_r_q;
    assign sound_valid = sound_valid_q;
    assign overrun     = overrun_q;

    // voice scaling, panning, drum summation and output saturation
    always_comb begin
        s        = {~wt_data[SAMPLE_W-1], wt_data[SAMPLE_W-2:0]};
        prod     = s * $signed({1'b0, env_q});
        p_d      = PW'(prod >>> ENV_W);
        ml       = p_q * $signed({1'b0, 5'd16 - pan_q});
        mr       = p_q * $signed({1'b0, pan_q});
        cl       = AW'(ml >>> 4);
        cr       = AW'(mr >>> 4);
        drum_sum = '0;
        raw      = '0;
        dv       = '0;
        for (int i = 0; i < DN; i++) begin
            raw = drum_q[i*DRUM_W +: DRUM_W] ^ (DRUM_W'(1) << (DRUM_W - 1));
            dv  = SAMPLE_W'(raw) << (SAMPLE_W - DRUM_W);
            if (NUM_DRUMS > 0 && dvalid_q[i]) drum_sum = drum_sum + AW'(dv);
        end
        sat_l = acc_l_q > MAXV ? MAXV : (acc_l_q < MINV ? MINV : acc_l_q);
        sat_r = acc_r_q > MAXV ? MAXV : (acc_r_q < MINV ? MINV : acc_r_q);
    end

    // frame sequencing
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: state_d = tick48k ? REQ : IDLE;
            REQ:  if (voice_ack) state_d = voice_active ? READ : (last ? DRUM : REQ);
            READ: state_d = MUL;
            MUL:  state_d = ACC;
            ACC:  state_d = last ? DRUM : REQ;
            DRUM: state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // datapath registers: voice parameters, accumulators and published output
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_q         <= '0;
            addr_q        <= '0;
            env_q         <= '0;
            pan_q         <= '0;
            p_q           <= '0;
            acc_l_q       <= '0;
            acc_r_q       <= '0;
            drum_q        <= '0;
            dvalid_q      <= '0;
            sound_l_q     <= MID;
            sound_r_q     <= MID;
            sound_valid_q <= 1'b0;
            overrun_q     <= 1'b0;
        end else begin
            sound_valid_q <= 1'b0;
            overrun_q     <= tick48k && state_q != IDLE;
            case (state_q)
                IDLE: if (tick48k) begin
                    acc_l_q  <= '0;
                    acc_r_q  <= '0;
                    drum_q   <= drum_sample;
                    dvalid_q <= drum_valid;
                    idx_q    <= '0;
                end
                REQ: if (voice_ack) begin
                    addr_q <= voice_addr;
                    env_q  <= voice_env;
                    pan_q  <= voice_pan > 5'd16 ? 5'd16 : voice_pan;
                    if (!voice_active) idx_q <= idx_q + 1'b1;
                end
                MUL: p_q <= p_d;
                ACC: begin
                    acc_l_q <= acc_l_q + cl;
                    acc_r_q <= acc_r_q + cr;
                    idx_q   <= idx_q + 1'b1;
                end
                DRUM: begin
                    acc_l_q <= acc_l_q + drum_sum;
                    acc_r_q <= acc_r_q + drum_sum;
                end
                DONE: begin
                    sound_l_q     <= sat_l[SAMPLE_W-1:0] ^ MID;
                    sound_r_q     <= sat_r[SAMPLE_W-1:0] ^ MID;
                    sound_valid_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_soundgen_poly.sv
// tb_soundgen_poly: directed scenario checks of the stereo voice/drum mixer
module tb_soundgen_poly;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick48k = 1'b0;
    logic        voice_req;
    logic [2:0]  voice_idx;
    logic        voice_ack;
    logic        voice_active;
    logic [9:0]  voice_addr;
    logic [17:0] voice_env;
    logic [4:0]  voice_pan;
    logic        wt_en;
    logic [9:0]  wt_addr;
    logic [17:0] wt_data = '0;
    logic [31:0] drum_sample = '0;
    logic [1:0]  drum_valid = '0;
    logic [17:0] sound_l, sound_r;
    logic        sound_valid, busy, overrun;

    logic [17:0] mem [8];
    logic        act [8];
    logic [17:0] env [8];
    logic [4:0]  pan [8];
    logic        stall_en = 1'b0;
    int          stall_cnt = 0;
    int          ov_cnt = 0;
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          t0, lat;

    soundgen_poly dut (
        .clk(clk), .rst_n(rst_n), .tick48k(tick48k),
        .voice_req(voice_req), .voice_idx(voice_idx), .voice_ack(voice_ack),
        .voice_active(voice_active), .voice_addr(voice_addr), .voice_env(voice_env),
        .voice_pan(voice_pan), .wt_en(wt_en), .wt_addr(wt_addr), .wt_data(wt_data),
        .drum_sample(drum_sample), .drum_valid(drum_valid),
        .sound_l(sound_l), .sound_r(sound_r), .sound_valid(sound_valid),
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (wt_en) wt_data <= mem[wt_addr[2:0]];
    always @(posedge clk) stall_cnt <= !stall_en ? 0 : (voice_req && voice_idx == 3'd3 && stall_cnt < 5) ? stall_cnt + 1 : stall_cnt;
    always @(negedge clk) if (overrun) ov_cnt <= ov_cnt + 1;

    assign voice_ack    = voice_req && !(stall_en && voice_idx == 3'd3 && stall_cnt < 5);
    assign voice_active = act[voice_idx];
    assign voice_addr   = {7'd0, voice_idx};
    assign voice_env    = env[voice_idx];
    assign voice_pan    = pan[voice_idx];

    task automatic clear_cfg();
        for (int i = 0; i < 8; i++) begin
            mem[i] = 18'h20000;
            act[i] = 1'b0;
            env[i] = 18'h3FFFF;
            pan[i] = 5'd8;
        end
        drum_sample = '0;
        drum_valid  = '0;
    endtask

    task automatic frame(output int latency);
        @(negedge clk);
        tick48k = 1'b1;
        t0 = cyc;
        @(negedge clk);
        tick48k = 1'b0;
        latency = -1;
        for (int n = 0; n < 200 && latency < 0; n++) begin
            if (sound_valid) latency = cyc - t0;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        if (sound_l !== 18'h20000) begin errors++; $display("FAIL reset_sound_l got %h exp 20000", sound_l); end
        checks++;
        if (sound_r !== 18'h20000) begin errors++; $display("FAIL reset_sound_r got %h exp 20000", sound_r); end
        checks++;
        if ({sound_valid, voice_req, wt_en, busy, overrun} !== 5'b0) begin errors++; $display("FAIL reset_ctl got %b exp 00000", {sound_valid, voice_req, wt_en, busy, overrun}); end
        checks++;
        if (voice_idx !== 3'd0 || wt_addr !== 10'd0) begin errors++; $display("FAIL reset_idx_addr got %h/%h exp 0/0", voice_idx, wt_addr); end
        checks++;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_voice();
        clear_cfg();
        mem[0] = 18'h30000;
        act[0] = 1'b1;
        frame(lat);
        if (lat !== 14) begin errors++; $display("FAIL single_latency got %0d exp 14", lat); end
        checks++;
        if (sound_l !== 18'h27FFF || sound_r !== 18'h27FFF) begin errors++; $display("FAIL single_out got %h/%h exp 27fff/27fff", sound_l, sound_r); end
        checks++;
        repeat (4) @(negedge clk);
        if (sound_l !== 18'h27FFF || sound_valid !== 1'b0) begin errors++; $display("FAIL single_hold got %h v%b exp 27fff v0", sound_l, sound_valid); end
        checks++;
    endtask

    task automatic test_all_voices();
        clear_cfg();
        for (int i = 0; i < 8; i++) begin
            mem[i] = 18'h3FFFF;
            act[i] = 1'b1;
            pan[i] = 5'd16;
        end
        frame(lat);
        if (lat !== 35) begin errors++; $display("FAIL all_latency got %0d exp 35", lat); end
        checks++;
        if (sound_r !== 18'h3FFFF) begin errors++; $display("FAIL all_r got %h exp 3ffff", sound_r); end
        checks++;
        if (sound_l !== 18'h20000) begin errors++; $display("FAIL all_l got %h exp 20000", sound_l); end
        checks++;
    endtask

    task automatic test_drums();
        clear_cfg();
        drum_sample = 32'h0000_0000;
        drum_valid  = 2'b11;
        frame(lat);
        if (lat !== 11) begin errors++; $display("FAIL drum_latency got %0d exp 11", lat); end
        checks++;
        if (sound_l !== 18'h00000 || sound_r !== 18'h00000) begin errors++; $display("FAIL drum_sat got %h/%h exp 00000/00000", sound_l, sound_r); end
        checks++;
        drum_valid = 2'b00;
        frame(lat);
        if (sound_l !== 18'h20000 || sound_r !== 18'h20000) begin errors++; $display("FAIL drum_invalid got %h/%h exp 20000/20000", sound_l, sound_r); end
        checks++;
        drum_sample = 32'h0000_FFFF;
        drum_valid  = 2'b01;
        frame(lat);
        if (sound_l !== 18'h3FFFC || sound_r !== 18'h3FFFC) begin errors++; $display("FAIL drum_max got %h/%h exp 3fffc/3fffc", sound_l, sound_r); end
        checks++;
    endtask

    task automatic test_pan_clamp();
        clear_cfg();
        mem[0] = 18'h30000;
        act[0] = 1'b1;
        pan[0] = 5'd31;
        frame(lat);
        if (sound_l !== 18'h20000 || sound_r !== 18'h2FFFF) begin errors++; $display("FAIL pan31 got %h/%h exp 20000/2ffff", sound_l, sound_r); end
        checks++;
        pan[0] = 5'd0;
        frame(lat);
        if (sound_l !== 18'h2FFFF || sound_r !== 18'h20000) begin errors++; $display("FAIL pan0 got %h/%h exp 2ffff/20000", sound_l, sound_r); end
        checks++;
    endtask

    task automatic test_stall_overrun();
        int ov0, n, bad;
        clear_cfg();
        mem[0] = 18'h30000;
        mem[3] = 18'h10000;
        act[0] = 1'b1;
        act[3] = 1'b1;
        stall_en = 1'b1;
        ov0 = ov_cnt;
        bad = 0;
        @(negedge clk);
        tick48k = 1'b1;
        t0 = cyc;
        @(negedge clk);
        tick48k = 1'b0;
        n = 0;
        while (!(voice_req && voice_idx == 3'd3) && n < 50) begin
            @(negedge clk);
            n++;
        end
        for (int j = 0; j < 5; j++) begin
            if (!(voice_req && voice_idx == 3'd3)) bad++;
            if (j == 1) tick48k = 1'b1;
            if (j == 2) tick48k = 1'b0;
            @(negedge clk);
        end
        if (bad !== 0 || n >= 50) begin errors++; $display("FAIL stall_hold got bad=%0d wait=%0d exp 0", bad, n); end
        checks++;
        lat = -1;
        for (int k = 0; k < 100 && lat < 0; k++) begin
            if (sound_valid) lat = cyc - t0;
            else @(negedge clk);
        end
        stall_en = 1'b0;
        if (lat !== 22) begin errors++; $display("FAIL stall_latency got %0d exp 22", lat); end
        checks++;
        if (sound_l !== 18'h1FFFF || sound_r !== 18'h1FFFF) begin errors++; $display("FAIL stall_out got %h/%h exp 1ffff/1ffff", sound_l, sound_r); end
        checks++;
        if (ov_cnt - ov0 !== 1) begin errors++; $display("FAIL overrun_count got %0d exp 1", ov_cnt - ov0); end
        checks++;
    endtask

    task automatic test_reset_mid();
        int n, seen;
        clear_cfg();
        for (int i = 0; i < 3; i++) begin
            mem[i] = 18'h30000;
            act[i] = 1'b1;
        end
        @(negedge clk);
        tick48k = 1'b1;
        @(negedge clk);
        tick48k = 1'b0;
        n = 0;
        while (!(wt_en && voice_idx == 3'd2) && n < 50) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        if (busy !== 1'b0 || voice_req !== 1'b0 || wt_en !== 1'b0 || n >= 50) begin errors++; $display("FAIL rstmid_ctl got busy%b req%b en%b wait=%0d exp 0", busy, voice_req, wt_en, n); end
        checks++;
        if (sound_l !== 18'h20000 || sound_r !== 18'h20000 || voice_idx !== 3'd0) begin errors++; $display("FAIL rstmid_out got %h/%h idx%0d exp 20000/20000 idx0", sound_l, sound_r, voice_idx); end
        checks++;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (50) begin
            @(negedge clk);
            if (sound_valid || busy) seen++;
        end
        if (seen !== 0) begin errors++; $display("FAIL rstmid_quiet got %0d exp 0", seen); end
        checks++;
        frame(lat);
        if (lat !== 20 || sound_l !== 18'h37FFD || sound_r !== 18'h37FFD) begin errors++; $display("FAIL rstmid_recover got lat%0d %h/%h exp lat20 37ffd/37ffd", lat, sound_l, sound_r); end
        checks++;
    endtask

    initial begin
        clear_cfg();
        test_reset();
        test_single_voice();
        test_all_voices();
        test_drums();
        test_pan_clamp();
        test_stall_overrun();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/soundgen_poly.md
# soundgen_poly

Parametrised stereo sound generator: on every 48 kHz frame tick it walks NUM_VOICES wavetable voices, scales each by its envelope, pans it into left/right, adds NUM_DRUMS drum samples, then saturates and publishes one stereo output sample. It sits between the voice/envelope control logic and the audio DAC/PWM output stage. It succeeds the fixed two-slot mixer with a configurable voice and drum count, per-voice panning, a request/acknowledge voice fetch and overflow saturation.

## Interface
- NUM_VOICES, 8: voices scanned per frame (≥1)
- NUM_DRUMS, 2: drum inputs mixed per frame (≥0)
- SAMPLE_W, 18: wavetable and output sample width, offset binary (midpoint 2^(SAMPLE_W-1))
- ADDR_W, 10: wavetable address width
- ENV_W, 18: unsigned envelope width
- DRUM_W, 16: drum sample width, offset binary, DRUM_W ≤ SAMPLE_W

- clk  in  1  system clock; the block uses this single clock
- rst_n  in  1  reset, asynchronous assert, active-low
- tick48k  in  1  frame start pulse
- voice_req  out  1  voice parameter request
- voice_idx  out  clog2(NUM_VOICES)  voice being requested
- voice_ack  in  1  parameters valid this cycle
- voice_active  in  1  voice sounding (sampled with ack)
- voice_addr  in  ADDR_W  wavetable address (sampled with ack)
- voice_env  in  ENV_W  envelope×velocity gain (sampled with ack)
- voice_pan  in  5  pan 0 (hard left) … 16 (hard right); >16 clamps to 16
- wt_en, wt_addr  out  1, ADDR_W  wavetable read strobe/address
- wt_data  in  SAMPLE_W  wavetable data, 1-cycle latency after wt_en
- drum_sample  in  NUM_DRUMS*DRUM_W  drum i at bits [i*DRUM_W +: DRUM_W]
- drum_valid  in  NUM_DRUMS  drum i present this frame
- sound_l, sound_r  out  SAMPLE_W  stereo output, offset binary
- sound_valid  out  1  one-cycle pulse when sound_l/r update
- busy  out  1  frame in progress
- overrun  out  1  one-cycle pulse: tick48k arrived while busy

## Operation
- States: IDLE, REQ, READ, MUL, ACC, DRUM, DONE.
- IDLE + tick48k: clear L/R accumulators, capture drum_sample/drum_valid, voice_idx←0, go REQ.
- REQ: voice_req=1, voice_idx stable until voice_ack=1 (ack in the first REQ cycle counts). On ack: register addr/env/pan; active → READ; inactive → next voice (REQ) or DRUM after the last voice.
- READ: wt_en=1, wt_addr=registered addr.
- MUL: s = wt_data with MSB inverted (signed); p = (s × env) >>> ENV_W (arithmetic shift, floor).
- ACC: acc_l += (p × (16−pan)) >>> 4; acc_r += (p × pan) >>> 4; then next voice or DRUM.
- DRUM: for each i with captured valid: d = {drum_i with MSB inverted, (SAMPLE_W−DRUM_W) zeros}, signed; added to both acc_l and acc_r.
- DONE: saturate each accumulator to [−2^(SAMPLE_W−1), 2^(SAMPLE_W−1)−1], invert MSB, register to sound_l/r, pulse sound_valid, go IDLE.
- Accumulator width SAMPLE_W + clog2(NUM_VOICES+NUM_DRUMS) + 1 signed; no wrap before saturation.
- tick48k while busy: ignored, overrun pulses, frame continues unchanged.
- busy=1 in every state except IDLE.

## Timing
- Reset values: sound_l = sound_r = 2^(SAMPLE_W−1), sound_valid 0, voice_req 0, voice_idx 0, wt_en 0, wt_addr 0, busy 0, overrun 0, state IDLE, accumulators 0.
- Tick at cycle T: REQ for voice 0 in T+1.
- Per voice with zero-wait ack: active 4 cycles (REQ, READ, MUL, ACC), inactive 1 cycle; each ack-wait cycle adds 1.
- sound_valid high in cycle T + 3 + Σ(per-voice cycles); all 8 voices active, no waits: T+35.
- rst_n low mid-frame: immediate abort, all outputs to reset values, no sound_valid until the next tick after release.
- Sound outputs hold their values between frames.

## Test plan
- Voice 0 only active: wt_data 0x30000, env 0x3FFFF, pan 8; others inactive, no drums → sound_l = sound_r = 0x27FFF, sound_valid at T+14.
- All 8 voices active: wt_data 0x3FFFF, env 0x3FFFF, pan 16 → sound_r = 0x3FFFF (saturated), sound_l = 0x20000, sound_valid at T+35.
- All voices inactive, both drums valid at 0x0000 → both channels −0x40000 saturated → sound_l = sound_r = 0x00000 at T+11; drums with drum_valid=0 → 0x20000.
- Pan clamp: one voice with pan 31 behaves exactly as pan 16 (left contribution 0).
- Hold voice_ack low 5 cycles on voice 3: voice_idx stays 3 with voice_req high, sound_valid 5 cycles later than nominal; a second tick48k during the frame → one overrun pulse, output unaffected.
- Drop rst_n during MUL of voice 2 → outputs immediately at reset values, busy 0; no sound_valid until the next tick after release.
